rr_arbiter_8ch: RTL and testbench

//   Round-robin arbiter sharing one resource among 8 requesters. Winner index is

---
 rtl/rr_arbiter_8ch_pkg.sv | 13 +
 rtl/rr_arbiter_8ch_pick.sv | 27 ++
 rtl/rr_arbiter_8ch.sv | 91 +++++++++
 tb/tb_rr_arbiter_8ch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_8ch_pkg.sv
// Shared constants and state encoding for the 8-channel round-robin arbiter.
package rr_arbiter_8ch_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // One-hot state encoding; 2'b00 and 2'b11 are illegal and recover to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_BUSY = 2'b10
    } state_t;

endpackage

// File: rtl/rr_arbiter_8ch_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr.
module rr_pick8
    import rr_arbiter_8ch_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset down so the nearest set bit wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8ch.sv
// Round-robin arbiter for 8 requesters with done/drop/timeout release.
module rr_arbiter_8ch
    import rr_arbiter_8ch_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             grant_vld,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] grant_oh,
    output logic             timeout_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_q, err_nxt;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    logic             rel_done, rel_drop, rel_to;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign rel_done = done;
    assign rel_drop = ~req[idx_q];
    assign rel_to   = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx_q;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    idx_nxt   = pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rel_done || rel_drop || rel_to) begin
                    ptr_nxt   = idx_q + IDX_W'(1);
                    state_nxt = ST_IDLE;
                    // Only flag a timeout when the owner gave no other reason to release.
                    err_nxt   = rel_to & ~rel_done & ~rel_drop;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            idx_q <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            idx_q <= idx_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    assign grant_vld   = (state == ST_BUSY);
    assign grant_idx   = idx_q;
    assign grant_oh    = grant_vld ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx_q) : '0;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_rr_arbiter_8ch.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_rr_arbiter_8ch;

    localparam int TO = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] req     = 8'h00;
    logic       done    = 1'b0;
    logic       grant_vld;
    logic [2:0] grant_idx;
    logic [7:0] grant_oh;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit run_cmp  = 1'b0;

    // Behavioural model: owner, cycles held so far, next search start.
    bit m_vld = 1'b0;
    int m_idx = 0;
    int m_age = 0;
    int m_ptr = 0;
    bit m_err = 1'b0;

    rr_arbiter_8ch #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .req         (req),
        .done        (done),
        .grant_vld   (grant_vld),
        .grant_idx   (grant_idx),
        .grant_oh    (grant_oh),
        .timeout_err (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_vld = 0; m_idx = 0; m_age = 0; m_ptr = 0; m_err = 0;
        end else if (!m_vld) begin
            m_err = 0;
            for (int k = 0; k < 8; k++) begin
                if (!m_vld && req[(m_ptr + k) % 8]) begin
                    m_vld = 1;
                    m_idx = (m_ptr + k) % 8;
                    m_age = 1;
                end
            end
        end else begin
            m_err = (m_age == TO) && !done && req[m_idx];
            if (done || !req[m_idx] || m_age == TO) begin
                m_vld = 0;
                m_ptr = (m_idx + 1) % 8;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (run_cmp) begin
            logic [7:0] exp_oh;
            exp_oh = 8'h00;
            for (int i = 0; i < 8; i++) if (m_vld && i == m_idx) exp_oh[i] = 1'b1;
            check("model_vld", {31'd0, grant_vld}, {31'd0, m_vld});
            check("model_idx", {29'd0, grant_idx}, m_idx);
            check("model_oh", {24'd0, grant_oh}, {24'd0, exp_oh});
            check("model_err", {31'd0, timeout_err}, {31'd0, m_err});
        end
    end

    task automatic nclk(input int n);
        for (int i = 0; i < n; i++) @(negedge sys_clk);
    endtask

    task automatic release_owner();
        done = 1'b1;
        nclk(1);
        check("release_vld", {31'd0, grant_vld}, 32'd0);
        done = 1'b0;
    endtask

    initial begin
        // Reset with all requests high.
        req = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge sys_clk);
            run_cmp = 1'b1;
            check("rst_vld", {31'd0, grant_vld}, 32'd0);
            check("rst_oh", {24'd0, grant_oh}, 32'd0);
            check("rst_err", {31'd0, timeout_err}, 32'd0);
        end
        req = 8'h00;
        sys_rst = 1'b0;
        nclk(1);

        // Single request on channel 4.
        req = 8'h10;
        nclk(1);
        check("single_idx", {29'd0, grant_idx}, 32'd4);
        check("single_oh", {24'd0, grant_oh}, 32'h10);
        release_owner();
        req = 8'hFF;
        nclk(1);
        check("single_ptr5", {29'd0, grant_idx}, 32'd5);
        release_owner();

        // Fairness from a fresh pointer.
        sys_rst = 1'b1;
        nclk(1);
        sys_rst = 1'b0;
        for (int g = 0; g < 9; g++) begin
            nclk(1);
            check("fair_vld", {31'd0, grant_vld}, 32'd1);
            check("fair_idx", {29'd0, grant_idx}, g % 8);
            release_owner();
        end

        // Wrap 6 -> 7 -> 0.
        req = 8'h40;
        nclk(1);
        check("wrap_6", {29'd0, grant_idx}, 32'd6);
        done = 1'b1;
        nclk(1);
        done = 1'b0;
        req = 8'h81;
        nclk(1);
        check("wrap_7", {29'd0, grant_idx}, 32'd7);
        release_owner();
        nclk(1);
        check("wrap_0", {29'd0, grant_idx}, 32'd0);
        release_owner();

        // Timeout with channel 2 held and never done.
        req = 8'h04;
        begin
            int hi, errs;
            bit fin;
            hi = 0; errs = 0; fin = 0;
            for (int i = 0; i < 40 && !fin; i++) begin
                nclk(1);
                if (grant_vld) hi++;
                if (timeout_err) begin
                    errs++;
                    check("to_err_at_drop", {31'd0, grant_vld}, 32'd0);
                end
                if (hi > 0 && !grant_vld) fin = 1;
            end
            check("to_finished", {31'd0, fin}, 32'd1);
            check("to_hold", hi, TO);
            check("to_errs", errs, 32'd1);
        end
        req = 8'hFF;
        nclk(1);
        check("to_ptr3", {29'd0, grant_idx}, 32'd3);
        check("to_err_clear", {31'd0, timeout_err}, 32'd0);
        release_owner();

        // done on the last allowed cycle: no timeout flag.
        req = 8'h02;
        nclk(1);
        check("c_grant1", {29'd0, grant_idx}, 32'd1);
        nclk(TO - 1);
        check("c_still_held", {31'd0, grant_vld}, 32'd1);
        done = 1'b1;
        nclk(1);
        done = 1'b0;
        check("c_done_vld", {31'd0, grant_vld}, 32'd0);
        check("c_done_noerr", {31'd0, timeout_err}, 32'd0);

        // Reset while busy.
        req = 8'hFF;
        nclk(3);
        check("c_busy", {31'd0, grant_vld}, 32'd1);
        sys_rst = 1'b1;
        nclk(1);
        sys_rst = 1'b0;
        check("c_rst_vld", {31'd0, grant_vld}, 32'd0);
        check("c_rst_err", {31'd0, timeout_err}, 32'd0);
        nclk(1);
        check("c_rst_ptr0", {29'd0, grant_idx}, 32'd0);

        // Owner drops its request.
        req = 8'hFE;
        nclk(1);
        check("c_drop_vld", {31'd0, grant_vld}, 32'd0);
        check("c_drop_err", {31'd0, timeout_err}, 32'd0);
        nclk(1);
        check("c_drop_next", {29'd0, grant_idx}, 32'd1);

        // Random traffic; model comparison does the checking.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) req = 8'($urandom_range(0, 255));
            done    = ($urandom_range(0, 9) == 0);
            sys_rst = ($urandom_range(0, 199) == 0);
            nclk(1);
        end
        sys_rst = 1'b0;
        done = 1'b0;
        nclk(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
